bus_cycle_ctrl: RTL and testbench



---
 rtl/bus_cycle_pkg.sv | 33 +++
 rtl/bus_watchdog.sv | 37 +++
 rtl/bus_cycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the 68030 bus cycle controller.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    WAIT   = 3'd2,
    TERM   = 3'd3,
    MODE   = 3'd4,
    AVEC   = 3'd5,
    BERR   = 3'd6,
    END    = 3'd7
  } state_t;

  localparam logic [1:0] PORT8      = 2'b10;
  localparam logic [1:0] PORT16     = 2'b01;
  localparam logic [1:0] PORT32     = 2'b00;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Returns field idx (width bits, zero-extended to 16) of a packed per-region vector.
  function automatic logic [15:0] field_of(input logic [127:0] vec, input int idx,
                                           input int width);
    logic [127:0] shifted;
    logic [15:0]  f;
    shifted = vec >> (idx * width);
    f = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < width) f[b] = shifted[b];
    end
    return f;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-timeout counter for unclaimed cycles; only built with BUS_CYCLE_WATCHDOG_EN.
module bus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic clr_n,
  input  logic run,
  output logic timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates on the last count so a late claim never sees a wrapped value.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = run && (cnt_q == LAST);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68030 memory/peripheral cycle controller: chip enables, strobes, nDsack/nAvec/nBerr.
// Optional bus-timeout watchdog enabled by defining BUS_CYCLE_WATCHDOG_EN.
module bus_cycle_ctrl
  import bus_cycle_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W = 4,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAITS = {4'd1, 4'd1, 4'd2, 4'd3},
  parameter logic [NUM_REGIONS*2-1:0] REGION_PORT = {2'b00, 2'b01, 2'b10, 2'b10},
  parameter int BERR_TIMEOUT = 64
) (
  input  logic                   sysClk,
  input  logic                   nReset,
  input  logic                   nAS,
  input  logic                   RnW,
  input  logic [2:0]             cpuFC,
  input  logic [NUM_REGIONS-1:0] regionHit,
  input  logic                   modeHit,
  input  logic                   avecHit,
  output logic [NUM_REGIONS-1:0] nCE,
  output logic                   nMemRd,
  output logic                   nMemWr,
  output logic [1:0]             nDsack,
  output logic                   nBerr,
  output logic                   nAvec,
  output logic                   overlay
);

  // A negated address strobe clears the cycle exactly like reset, without a clock.
  logic clr_n;
  assign clr_n = nReset & ~nAS;

  state_t                 state_q, state_d;
  logic [2:0]             region_q, region_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] nce_q, nce_d;
  logic                   nrd_q, nrd_d;
  logic                   nwr_q, nwr_d;
  logic [1:0]             dsack_q, dsack_d;
  logic                   nberr_q, nberr_d;
  logic                   navec_q, navec_d;
  logic                   overlay_q, overlay_d;

  logic [WAIT_W-1:0]      region_wait [NUM_REGIONS];
  logic [1:0]             region_port [NUM_REGIONS];

  genvar gi;
  for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    localparam logic [15:0] WAIT_FIELD = field_of(128'(REGION_WAITS), gi, WAIT_W);
    localparam logic [15:0] PORT_FIELD = field_of(128'(REGION_PORT), gi, 2);
    assign region_wait[gi] = WAIT_FIELD[WAIT_W-1:0];
    assign region_port[gi] = PORT_FIELD[1:0];
  end

  logic wd_timeout;
`ifdef BUS_CYCLE_WATCHDOG_EN
  bus_watchdog #(
    .TIMEOUT(BERR_TIMEOUT)
  ) u_watchdog (
    .clk    (sysClk),
    .clr_n  (clr_n),
    .run    (state_q == IDLE),
    .timeout(wd_timeout)
  );
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^BERR_TIMEOUT;
  assign wd_timeout = 1'b0;
`endif

  logic unused_fc;
  assign unused_fc = ^cpuFC;

  logic [2:0]             hit_idx;
  logic [WAIT_W-1:0]      wait_sel;
  logic [1:0]             port_raw;
  logic [1:0]             port_sel;
  logic [NUM_REGIONS-1:0] nce_sel;

  always_comb begin : region_lookup
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (regionHit[i]) hit_idx = 3'(i);
    end
    wait_sel = '0;
    port_raw = DSACK_NONE;
    nce_sel  = '1;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_q == 3'(i)) begin
        wait_sel   = region_wait[i];
        port_raw   = region_port[i];
        nce_sel[i] = 1'b0;
      end
    end
    // An "11" code would never terminate the cycle; treat it as a 32-bit port.
    case (port_raw)
      PORT8, PORT16, PORT32: port_sel = port_raw;
      default:               port_sel = PORT32;
    endcase
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    nce_d    = nce_q;
    nrd_d    = nrd_q;
    nwr_d    = nwr_q;
    dsack_d  = dsack_q;
    nberr_d  = nberr_q;
    navec_d  = navec_q;
    case (state_q)
      IDLE: begin
        if (avecHit) begin
          state_d = AVEC;
        end else if (|regionHit) begin
          state_d  = ACTIVE;
          region_d = hit_idx;
        end else if (modeHit && !RnW) begin
          state_d = MODE;
        end else if (wd_timeout) begin
          state_d = BERR;
        end
      end
      ACTIVE: begin
        nce_d   = nce_sel;
        nrd_d   = ~RnW;
        nwr_d   = RnW;
        cnt_d   = wait_sel;
        state_d = (wait_sel == '0) ? TERM : WAIT;
      end
      WAIT: begin
        if (cnt_q <= WAIT_W'(1)) state_d = TERM;
        if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
      end
      TERM: begin
        dsack_d = port_sel;
        state_d = END;
      end
      MODE: begin
        dsack_d = PORT8;
        state_d = END;
      end
      AVEC: begin
        navec_d = 1'b0;
        state_d = END;
      end
      BERR: begin
        nberr_d = 1'b0;
        state_d = END;
      end
      END: begin
        nwr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      region_q <= '0;
      cnt_q    <= '0;
      nce_q    <= '1;
      nrd_q    <= 1'b1;
      nwr_q    <= 1'b1;
      dsack_q  <= DSACK_NONE;
      nberr_q  <= 1'b1;
      navec_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      nce_q    <= nce_d;
      nrd_q    <= nrd_d;
      nwr_q    <= nwr_d;
      dsack_q  <= dsack_d;
      nberr_q  <= nberr_d;
      navec_q  <= navec_d;
    end
  end

  // Overlay survives nAS negation; only a real reset clears it.
  always_comb begin
    overlay_d = overlay_q ^ ((state_q == MODE) && !nAS);
  end

  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      overlay_q <= 1'b0;
    end else begin
      overlay_q <= overlay_d;
    end
  end

  assign nCE     = nce_q;
  assign nMemRd  = nrd_q;
  assign nMemWr  = nwr_q;
  assign nDsack  = dsack_q;
  assign nBerr   = nberr_q;
  assign nAvec   = navec_q;
  assign overlay = overlay_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl against a cycle-level timeline model.
module tb_bus_cycle_ctrl;

  localparam int T = 8;
  localparam int K_NONE = 0;
  localparam int K_REGION = 1;
  localparam int K_MODE = 2;
  localparam int K_AVEC = 3;

  logic       sysClk = 1'b0;
  logic       nReset;
  logic       nAS;
  logic       RnW;
  logic [2:0] cpuFC;
  logic [3:0] regionHit;
  logic       modeHit;
  logic       avecHit;
  logic [3:0] nCE;
  logic       nMemRd;
  logic       nMemWr;
  logic [1:0] nDsack;
  logic       nBerr;
  logic       nAvec;
  logic       overlay;

  bus_cycle_ctrl #(
    .NUM_REGIONS (4),
    .WAIT_W      (4),
    .REGION_WAITS({4'd0, 4'd1, 4'd2, 4'd3}),
    .REGION_PORT ({2'b00, 2'b01, 2'b10, 2'b10}),
    .BERR_TIMEOUT(T)
  ) dut (
    .sysClk   (sysClk),
    .nReset   (nReset),
    .nAS      (nAS),
    .RnW      (RnW),
    .cpuFC    (cpuFC),
    .regionHit(regionHit),
    .modeHit  (modeHit),
    .avecHit  (avecHit),
    .nCE      (nCE),
    .nMemRd   (nMemRd),
    .nMemWr   (nMemWr),
    .nDsack   (nDsack),
    .nBerr    (nBerr),
    .nAvec    (nAvec),
    .overlay  (overlay)
  );

  always #5 sysClk = ~sysClk;

  int checks = 0;
  int errors = 0;
  logic ov_model = 1'b0;
  int waits [4] = '{3, 2, 1, 0};
  logic [1:0] ports [4] = '{2'b10, 2'b10, 2'b01, 2'b00};

  logic [10:0] obs;
  assign obs = {nCE, nMemRd, nMemWr, nDsack, nBerr, nAvec, overlay};

  function automatic logic [10:0] idle_vec(input logic ov);
    return {4'hF, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, ov};
  endfunction

  function automatic int kind_of(input logic [3:0] hit, input logic av, input logic md,
                                 input logic rnw);
    if (av) return K_AVEC;
    if (hit != 4'b0000) return K_REGION;
    if (md && !rnw) return K_MODE;
    return K_NONE;
  endfunction

  // Expected outputs k clocks after the edge that first samples nAS low.
  function automatic logic [10:0] model_out(input logic [3:0] hit, input logic av,
                                            input logic md, input logic rnw, input int k,
                                            input logic ov0);
    logic [3:0] nce;
    logic rd, wr, berr, avn, ov;
    logic [1:0] ds;
    int sel, n;
    nce = 4'hF; rd = 1'b1; wr = 1'b1; ds = 2'b11; berr = 1'b1; avn = 1'b1; ov = ov0;
    sel = 0;
    case (kind_of(hit, av, md, rnw))
      K_REGION: begin
        for (int j = 0; j < 4; j++) begin
          if (hit[j]) begin sel = j; break; end
        end
        n = waits[sel];
        if (k >= 1) begin
          nce[sel] = 1'b0;
          rd = ~rnw;
          wr = (k >= n + 3) ? 1'b1 : rnw;
          if (k >= n + 2) ds = ports[sel];
        end
      end
      K_AVEC: if (k >= 1) avn = 1'b0;
      K_MODE: if (k >= 1) begin ds = 2'b10; ov = ~ov0; end
      default: begin
`ifdef BUS_CYCLE_WATCHDOG_EN
        if (k >= T) berr = 1'b0;
`endif
      end
    endcase
    return {nce, rd, wr, ds, berr, avn, ov};
  endfunction

  task automatic start_cycle(input logic [3:0] hit, input logic av, input logic md,
                             input logic rnw);
    @(negedge sysClk);
    regionHit = hit;
    avecHit = av;
    modeHit = md;
    RnW = rnw;
    cpuFC = 3'($urandom_range(0, 7));
    nAS = 1'b0;
  endtask

  task automatic end_cycle();
    #2;
    nAS = 1'b1;
    regionHit = 4'b0000;
    avecHit = 1'b0;
    modeHit = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    nReset = 1'b0; nAS = 1'b1; RnW = 1'b1; cpuFC = 3'd0;
    regionHit = 4'b0000; modeHit = 1'b0; avecHit = 1'b0;
    repeat (3) @(negedge sysClk);
    e = idle_vec(1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold got %b expected %b", obs, e); end
    nReset = 1'b1;
    repeat (2) @(negedge sysClk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release got %b expected %b", obs, e); end
    ov_model = 1'b0;
    $display("txn reset obs=%b", obs);
  endtask

  task automatic test_default_read();
    logic [10:0] e;
    start_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b0001, 1'b0, 1'b0, 1'b1, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL default_read k=%0d got %b expected %b", k, obs, e); end
    end
    end_cycle();
    e = idle_vec(ov_model);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL default_read_async_release got %b expected %b", obs, e); end
    $display("txn default_read region0 obs=%b", obs);
  endtask

  task automatic test_zero_wait_write();
    logic [10:0] e;
    start_cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b1000, 1'b0, 1'b0, 1'b0, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL zero_wait_write k=%0d got %b expected %b", k, obs, e); end
    end
    end_cycle();
    e = idle_vec(ov_model);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL zero_wait_release got %b expected %b", obs, e); end
    $display("txn zero_wait_write region3 obs=%b", obs);
  endtask

  task automatic test_mode_twice();
    logic [10:0] e;
    for (int r = 0; r < 2; r++) begin
      start_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k <= 3; k++) begin
        @(posedge sysClk); @(negedge sysClk);
        e = model_out(4'b0000, 1'b0, 1'b1, 1'b0, k, ov_model);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL mode_toggle r=%0d k=%0d got %b expected %b", r, k, obs, e); end
      end
      end_cycle();
      ov_model = ~ov_model;
      e = idle_vec(ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL mode_release r=%0d got %b expected %b", r, obs, e); end
      $display("txn mode_write r=%0d overlay=%b", r, overlay);
    end
  endtask

  task automatic test_avec_priority();
    logic [10:0] e;
    start_cycle(4'b0010, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b0010, 1'b1, 1'b0, 1'b1, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL avec_priority k=%0d got %b expected %b", k, obs, e); end
    end
    end_cycle();
    $display("txn avec_with_region1 obs=%b", obs);
  endtask

  task automatic test_region_over_mode();
    logic [10:0] e;
    start_cycle(4'b0100, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b0100, 1'b0, 1'b1, 1'b0, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL region_over_mode k=%0d got %b expected %b", k, obs, e); end
    end
    end_cycle();
    $display("txn region2_with_mode obs=%b", obs);
  endtask

  task automatic test_no_claim();
    logic [10:0] e;
    int len;
`ifdef BUS_CYCLE_WATCHDOG_EN
    len = T + 3;
`else
    len = 100;
`endif
    start_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= len; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b0000, 1'b0, 1'b0, 1'b1, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL no_claim k=%0d got %b expected %b", k, obs, e); end
    end
    end_cycle();
    e = idle_vec(ov_model);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL no_claim_release got %b expected %b", obs, e); end
    $display("txn unclaimed len=%0d nBerr=%b", len, nBerr);
  endtask

  task automatic test_reset_mid_wait();
    logic [10:0] e;
    if (!ov_model) begin
      start_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k <= 2; k++) begin
        @(posedge sysClk); @(negedge sysClk);
        e = model_out(4'b0000, 1'b0, 1'b1, 1'b0, k, ov_model);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL set_overlay k=%0d got %b expected %b", k, obs, e); end
      end
      end_cycle();
      ov_model = 1'b1;
    end
    start_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 2; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b0001, 1'b0, 1'b0, 1'b1, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL pre_reset_wait k=%0d got %b expected %b", k, obs, e); end
    end
    #2;
    nReset = 1'b0;
    #1;
    e = idle_vec(1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mid_wait got %b expected %b", obs, e); end
    nAS = 1'b1;
    regionHit = 4'b0000;
    @(negedge sysClk);
    nReset = 1'b1;
    ov_model = 1'b0;
    start_cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(posedge sysClk); @(negedge sysClk);
      e = model_out(4'b0100, 1'b0, 1'b0, 1'b0, k, ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL post_reset_cycle k=%0d got %b expected %b", k, obs, e); end
    end
    end_cycle();
    $display("txn reset_mid_wait overlay=%b", overlay);
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [3:0] hit;
    logic av, md, rnw;
    int len;
    for (int t = 0; t < 40; t++) begin
      hit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) hit = 4'b0000;
      av = ($urandom_range(0, 7) == 0);
      md = 1'($urandom_range(0, 1));
      rnw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      start_cycle(hit, av, md, rnw);
      for (int k = 0; k <= len; k++) begin
        @(posedge sysClk); @(negedge sysClk);
        e = model_out(hit, av, md, rnw, k, ov_model);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL random t=%0d k=%0d got %b expected %b", t, k, obs, e); end
      end
      end_cycle();
      if (kind_of(hit, av, md, rnw) == K_MODE) ov_model = ~ov_model;
      e = idle_vec(ov_model);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL random_release t=%0d got %b expected %b", t, obs, e); end
      $display("txn %0d hit=%b av=%b md=%b rnw=%b len=%0d overlay=%b", t, hit, av, md, rnw, len, overlay);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_default_read();
    test_zero_wait_write();
    test_mode_twice();
    test_avec_priority();
    test_region_over_mode();
    test_no_claim();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
